// File: rtl/uart_pkg.sv
// Shared UART-side types for the baud-rate configuration path.
package uart_pkg;

  // Divisor width; must match the baud generator's counter.
  localparam int DVSR_W = 11;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    MEASURE,
    CALC
  } autobaud_state_t;

endpackage

// File: rtl/rx_sync_edge.sv
// Two-flop synchroniser for the raw rx pin plus a falling-edge pulse.
// All flops reset to 1 (line idle) so leaving reset never looks like a fall.
module rx_sync_edge (
  input  logic clk,
  input  logic reset_n,
  input  logic i_rx,
  output logic o_fall
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  // Synchronise rx and keep one cycle of history for edge detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
      r_prev <= 1'b1;
    end else begin
      r_meta <= i_rx;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_fall = r_prev & ~r_sync;

endmodule

// File: rtl/autobaud_ctrl.sv
// Baud divisor controller: software-loaded divisor or auto-baud measurement of a
// 0x55 sync character. Optional fall-to-fall interval check: AUTOBAUD_CHECK_EN.
//
// state   | meaning
// IDLE    | divisor stable, waiting for start
// ARMED   | waiting for the start-bit fall of the sync character
// MEASURE | counting cycles across the first five falls (8 bit periods)
// CALC    | divide the count down to a divisor and range-check it
module autobaud_ctrl
  import uart_pkg::*;
#(
  parameter int CNT_W        = 20,
  parameter int DEFAULT_DVSR = 650,
  parameter int MIN_DVSR     = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              rx,
  input  logic              start,
  input  logic              sw_we,
  input  logic [DVSR_W-1:0] sw_dvsr,
  output logic [DVSR_W-1:0] dvsr,
  output logic              gen_clr,
  output logic              busy,
  output logic              locked,
  output logic              err
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  autobaud_state_t   r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [2:0]        r_edges;
  logic [DVSR_W-1:0] r_dvsr;
  logic              r_gen_clr;
  logic              r_locked;
  logic              r_err;

  logic              w_fall;
  logic [CNT_W:0]    w_sum;
  logic [CNT_W:0]    w_q;
  logic              w_q_ok;
  logic [DVSR_W-1:0] w_cand;
  logic              w_intv_bad;

  rx_sync_edge u_rx (
    .clk     (clk),
    .reset_n (reset_n),
    .i_rx    (rx),
    .o_fall  (w_fall)
  );

  // Eight bit times over 128 (8 bits x 16 oversample), rounded; one extra bit keeps the add from wrapping.
  assign w_sum  = {1'b0, r_cnt} + (CNT_W+1)'(64);
  assign w_q    = w_sum >> 7;
  assign w_q_ok = (w_q > (CNT_W+1)'(MIN_DVSR)) && (w_q <= (CNT_W+1)'(2**DVSR_W));
  assign w_cand = DVSR_W'(w_q - (CNT_W+1)'(1));

`ifdef AUTOBAUD_CHECK_EN
  logic [CNT_W-1:0] r_last;
  logic [CNT_W-1:0] r_i1;
  logic [CNT_W-1:0] w_intv;
  logic [CNT_W-1:0] w_lo;
  logic [CNT_W:0]   w_hi;

  assign w_intv     = r_cnt - r_last;
  assign w_lo       = r_i1 - (r_i1 >> 2);
  assign w_hi       = {1'b0, r_i1} + {3'b000, r_i1[CNT_W-1:2]};
  // The first interval (second fall) is the reference and is never judged itself.
  assign w_intv_bad = (r_edges != 3'd1) && ((w_intv < w_lo) || ({1'b0, w_intv} > w_hi));

  // Track the count at the previous fall and latch the first interval as reference.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_last <= '0;
      r_i1   <= '0;
    end else if (r_state == ARMED) begin
      r_last <= '0;
    end else if (r_state == MEASURE && w_fall) begin
      r_last <= r_cnt;
      if (r_edges == 3'd1) r_i1 <= w_intv;
    end
  end
`else
  assign w_intv_bad = 1'b0;
`endif

  // Sequencing FSM; a software write overrides every measurement event in the same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_edges   <= '0;
      r_dvsr    <= DVSR_W'(DEFAULT_DVSR);
      r_gen_clr <= 1'b0;
      r_locked  <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_gen_clr <= 1'b0;
      if (sw_we) begin
        r_dvsr    <= sw_dvsr;
        r_gen_clr <= 1'b1;
        r_locked  <= 1'b0;
        r_err     <= 1'b0;
        r_state   <= IDLE;
      end else begin
        case (r_state)
          IDLE: begin
            if (start) begin
              r_state  <= ARMED;
              r_locked <= 1'b0;
              r_err    <= 1'b0;
            end
          end
          ARMED: begin
            if (w_fall) begin
              r_state <= MEASURE;
              r_cnt   <= CNT_W'(1);
              r_edges <= 3'd1;
            end
          end
          MEASURE: begin
            if (r_cnt == CNT_MAX) begin
              r_state <= IDLE;
              r_err   <= 1'b1;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
              if (w_fall) begin
                r_edges <= r_edges + 3'd1;
                if (w_intv_bad) begin
                  r_state <= IDLE;
                  r_err   <= 1'b1;
                end else if (r_edges == 3'd4) begin
                  r_state <= CALC;
                end
              end
            end
          end
          CALC: begin
            r_state <= IDLE;
            if (w_q_ok) begin
              r_dvsr    <= w_cand;
              r_locked  <= 1'b1;
              r_gen_clr <= 1'b1;
            end else begin
              r_err <= 1'b1;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign dvsr    = r_dvsr;
  assign gen_clr = r_gen_clr;
  assign locked  = r_locked;
  assign err     = r_err;
  assign busy    = (r_state != IDLE);

endmodule
